// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry in-order result buffer between the ALU and
// writeback, plus the architectural {N,Z,C,V} flag register.
// Optional feature macro: ALU_STICKY_OV_EN (builds the sticky overflow bit).
module alu_result_stage #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned RD_W  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [23:0]     in_result,
  input  logic            in_zero,
  input  logic            in_carry,
  input  logic            in_overflow,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_wr_en,
  input  logic            in_set_flags,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [23:0]     out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_wr_en,
  output logic [3:0]      flags,
  output logic            ov_sticky
);

  localparam int unsigned DATA_W   = 24;
  localparam logic [1:0]  FULL_CNT = 2'(DEPTH);

  // State encoding equals buffer occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd;
    logic              wr_en;
  } entry_t;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  logic [3:0] flags_q, flags_d;
  entry_t in_entry;
  logic push;
  logic pop;

  assign in_ready = (2'(state_q) != FULL_CNT) & ~rst;
  assign out_valid = (state_q != EMPTY);
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
  assign in_entry = '{result: in_result, rd: in_rd, wr_en: in_wr_en};

  assign out_result = head_q.result;
  assign out_rd     = head_q.rd;
  assign out_wr_en  = head_q.wr_en;
  assign flags      = flags_q;

  // State, buffer and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      flags_q <= flags_d;
    end
  end

  // Occupancy transitions, head/tail movement and flag capture; flush wins.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    flags_d = flags_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = in_entry;
          end else if (push) begin
            tail_d  = in_entry;
            state_d = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
      if (push && in_set_flags) begin
        flags_d = {in_result[DATA_W-1], in_zero, in_carry, in_overflow};
      end
    end
  end

`ifdef ALU_STICKY_OV_EN
  logic sticky_q, sticky_d;

  // Sticky overflow: set by any surviving flag-setting push with overflow.
  always_comb begin
    sticky_d = sticky_q;
    if (push && in_set_flags && in_overflow && !flush) begin
      sticky_d = 1'b1;
    end
  end

  // Sticky register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign ov_sticky = sticky_q;
`else
  assign ov_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage; honours ALU_STICKY_OV_EN.
module tb_alu_result_stage;

  localparam int unsigned RD_W = 3;
`ifdef ALU_STICKY_OV_EN
  localparam logic STICKY_ON = 1'b1;
`else
  localparam logic STICKY_ON = 1'b0;
`endif

  typedef struct {
    logic [23:0]     result;
    logic [RD_W-1:0] rd;
    logic            wr_en;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [23:0]     in_result;
  logic            in_zero;
  logic            in_carry;
  logic            in_overflow;
  logic [RD_W-1:0] in_rd;
  logic            in_wr_en;
  logic            in_set_flags;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [23:0]     out_result;
  logic [RD_W-1:0] out_rd;
  logic            out_wr_en;
  logic [3:0]      flags;
  logic            ov_sticky;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pops = 0;
  exp_t sb[$];
  logic [3:0] exp_flags = 4'b0000;
  logic       exp_sticky = 1'b0;

  alu_result_stage #(.DEPTH(2), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_zero(in_zero), .in_carry(in_carry),
    .in_overflow(in_overflow), .in_rd(in_rd), .in_wr_en(in_wr_en),
    .in_set_flags(in_set_flags), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wr_en(out_wr_en),
    .flags(flags), .ov_sticky(ov_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard and flag model updated at every rising edge.
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      exp_flags  = 4'b0000;
      exp_sticky = 1'b0;
    end else begin
      n_cmp++;
      if (out_valid !== (sb.size() != 0)) begin
        n_err++;
        $display("FAIL occupancy: out_valid=%b expected=%b", out_valid, sb.size() != 0);
      end
      n_cmp++;
      if (in_ready !== (sb.size() < 2)) begin
        n_err++;
        $display("FAIL in_ready_model: got=%b expected=%b", in_ready, sb.size() < 2);
      end
      n_cmp++;
      if (flags !== exp_flags) begin
        n_err++;
        $display("FAIL flags_model: got=%b expected=%b", flags, exp_flags);
      end
      n_cmp++;
      if (ov_sticky !== exp_sticky) begin
        n_err++;
        $display("FAIL sticky_model: got=%b expected=%b", ov_sticky, exp_sticky);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        n_pops++;
        n_cmp++;
        if (out_result !== e.result || out_rd !== e.rd || out_wr_en !== e.wr_en) begin
          n_err++;
          $display("FAIL pop_data: got=%h/%0d/%b expected=%h/%0d/%b",
                   out_result, out_rd, out_wr_en, e.result, e.rd, e.wr_en);
        end
      end
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        exp_t e;
        e.result = in_result;
        e.rd     = in_rd;
        e.wr_en  = in_wr_en;
        sb.push_back(e);
        if (in_set_flags) begin
          exp_flags = {in_result[23], in_zero, in_carry, in_overflow};
          if (in_overflow && STICKY_ON) exp_sticky = 1'b1;
        end
      end
    end
  end

  task automatic drive(input logic [23:0] res, input logic [RD_W-1:0] rd, input logic wr,
                       input logic sf, input logic z, input logic c, input logic ov);
    in_valid     = 1'b1;
    in_result    = res;
    in_rd        = rd;
    in_wr_en     = wr;
    in_set_flags = sf;
    in_zero      = z;
    in_carry     = c;
    in_overflow  = ov;
  endtask

  task automatic idle();
    in_valid     = 1'b0;
    in_set_flags = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got=%b expected=0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got=%b expected=0", out_valid); end
    n_cmp++; if (out_result !== 24'h0) begin n_err++; $display("FAIL reset_out_result: got=%h expected=0", out_result); end
    n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got=%b expected=0000", flags); end
    n_cmp++; if (ov_sticky !== 1'b0) begin n_err++; $display("FAIL reset_sticky: got=%b expected=0", ov_sticky); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got=%b expected=1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(24'h000005, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    idle();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got=%b expected=1", out_valid); end
    n_cmp++; if (out_result !== 24'h000005) begin n_err++; $display("FAIL single_result: got=%h expected=000005", out_result); end
    n_cmp++; if (out_rd !== 3'd3) begin n_err++; $display("FAIL single_rd: got=%0d expected=3", out_rd); end
    n_cmp++; if (out_wr_en !== 1'b1) begin n_err++; $display("FAIL single_wr_en: got=%b expected=1", out_wr_en); end
    n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL single_flags: got=%b expected=0000", flags); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got=%b expected=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(24'h111111, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_one: got=%b expected=1", in_ready); end
    drive(24'h222222, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full: got=%b expected=0", in_ready); end
    drive(24'h333333, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 24'h111111 || out_rd !== 3'd1) begin
        n_err++;
        $display("FAIL bp_hold: cycle=%0d ready=%b valid=%b result=%h rd=%0d expected 0/1/111111/1",
                 i, in_ready, out_valid, out_result, out_rd);
      end
    end
    idle();
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_result !== 24'h222222 || out_rd !== 3'd2) begin n_err++; $display("FAIL bp_second: got=%h/%0d expected=222222/2", out_result, out_rd); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got=%b expected=0", out_valid); end
  endtask

  task automatic test_flags();
    out_ready = 1'b1;
    drive(24'h800000, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++; if (flags !== 4'b1011) begin n_err++; $display("FAIL flags_set: got=%b expected=1011", flags); end
    drive(24'h000000, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    idle();
    n_cmp++; if (flags !== 4'b1011) begin n_err++; $display("FAIL flags_hold: got=%b expected=1011", flags); end
    @(negedge clk);
    n_cmp++; if (flags !== 4'b1011) begin n_err++; $display("FAIL flags_hold2: got=%b expected=1011", flags); end
  endtask

  task automatic test_sticky();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    drive(24'h000001, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++; if (ov_sticky !== STICKY_ON) begin n_err++; $display("FAIL sticky_first: got=%b expected=%b", ov_sticky, STICKY_ON); end
    n_cmp++; if (flags !== 4'b0001) begin n_err++; $display("FAIL sticky_flags1: got=%b expected=0001", flags); end
    drive(24'h000002, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    idle();
    n_cmp++; if (flags[0] !== 1'b0) begin n_err++; $display("FAIL sticky_v_clear: got=%b expected=0", flags[0]); end
    n_cmp++; if (ov_sticky !== STICKY_ON) begin n_err++; $display("FAIL sticky_second: got=%b expected=%b", ov_sticky, STICKY_ON); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(24'h800001, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(24'h000002, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0 || flags !== 4'b1010) begin n_err++; $display("FAIL flush_setup: ready=%b flags=%b expected 0/1010", in_ready, flags); end
    drive(24'h000000, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idle();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got=%b expected=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got=%b expected=1", in_ready); end
    n_cmp++; if (flags !== 4'b1010) begin n_err++; $display("FAIL flush_flags: got=%b expected=1010", flags); end
    drive(24'h0000EE, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(24'h000000, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || flags !== 4'b1010) begin n_err++; $display("FAIL flush_push: valid=%b flags=%b expected 0/1010", out_valid, flags); end
    drive(24'h00ABCD, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    idle();
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 24'h00ABCD) begin n_err++; $display("FAIL flush_after: valid=%b result=%h expected 1/00abcd", out_valid, out_result); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(24'h800000, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    drive(24'h123456, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (flags !== 4'b1111 || in_ready !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_setup: flags=%b ready=%b valid=%b expected 1111/0/1", flags, in_ready, out_valid); end
    rst = 1'b1;
    out_ready = 1'b1;
    drive(24'hABCDEF, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_ready: got=%b expected=0", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0 || out_result !== 24'h0 || out_rd !== 3'd0 || out_wr_en !== 1'b0 || flags !== 4'b0000 || ov_sticky !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_clear: valid=%b result=%h rd=%0d wr=%b flags=%b sticky=%b expected all zero",
               out_valid, out_result, out_rd, out_wr_en, flags, ov_sticky);
    end
    rst = 1'b0;
    idle();
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_release: ready=%b valid=%b expected 1/0", in_ready, out_valid); end
    drive(24'h0A0B0C, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    idle();
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 24'h0A0B0C || out_rd !== 3'd5) begin n_err++; $display("FAIL rmid_push: valid=%b result=%h rd=%0d expected 1/0a0b0c/5", out_valid, out_result, out_rd); end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_drain: got=%b expected=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int p0;
    logic [23:0] v;
    p0 = n_pops;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = 24'(i * 24'h010101 + 24'h000100);
      drive(v, 3'(i), i[0], 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_result !== v) begin
        n_err++;
        $display("FAIL b2b: i=%0d ready=%b valid=%b result=%h expected 1/1/%h", i, in_ready, out_valid, out_result, v);
      end
    end
    idle();
    @(negedge clk);
    n_cmp++; if ((n_pops - p0) !== 8) begin n_err++; $display("FAIL b2b_count: got=%0d expected=8", n_pops - p0); end
    n_cmp++; if (sb.size() !== 0) begin n_err++; $display("FAIL b2b_leftover: got=%0d expected=0", sb.size()); end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    in_result = '0;
    in_zero = 1'b0;
    in_carry = 1'b0;
    in_overflow = 1'b0;
    in_rd = '0;
    in_wr_en = 1'b0;
    in_set_flags = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_flags();
    test_sticky();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
